// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, used by the timing generator and the pattern stage.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
        logic line_end;
        logic frame_end;
    } vga_flags_t;

    // Flag values that belong to coordinate (0, 0).
    localparam vga_flags_t FLAGS_RESET = '{
        hsync:      1'b1,
        vsync:      1'b1,
        display_on: 1'b1,
        line_end:   1'b0,
        frame_end:  1'b0
    };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible/last flags decoded from the next count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               next_sync_active,
    output logic               next_visible,
    output logic               next_last
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(DISPLAY + FRONT);
    localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(DISPLAY + FRONT + SYNC - 1);
    localparam logic [COORD_W-1:0] VIS_LIMIT  = COORD_W'(DISPLAY);

    logic [COORD_W-1:0] next_count;

    always_comb begin
        wrap = inc && (count == LAST);
        if (wrap) begin
            next_count = '0;
        end else if (inc) begin
            next_count = count + 1'b1;
        end else begin
            next_count = count;
        end
    end

    // Flags look at the value the counter is about to hold so that registered
    // flags line up with the registered count.
    always_comb begin
        next_sync_active = (next_count >= SYNC_FIRST) && (next_count <= SYNC_LAST);
        next_visible     = (next_count < VIS_LIMIT);
        next_last        = (next_count == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters with registered active-low syncs, display enable and end-of-line/frame pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_SUM = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_SUM = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if ((H_SUM > (1 << COORD_W)) || (V_SUM > (1 << COORD_W))) begin : g_size_check
            $error("vga_timing_gen: line or frame total exceeds the coordinate range");
        end
    endgenerate

    logic h_wrap;
    logic h_sync_active;
    logic h_visible;
    logic h_last;
    logic unused_v_wrap;
    logic v_sync_active;
    logic v_visible;
    logic v_last;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk              (clk),
        .rst              (rst),
        .inc              (ce),
        .count            (x),
        .wrap             (h_wrap),
        .next_sync_active (h_sync_active),
        .next_visible     (h_visible),
        .next_last        (h_last)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk              (clk),
        .rst              (rst),
        .inc              (h_wrap),
        .count            (y),
        .wrap             (unused_v_wrap),
        .next_sync_active (v_sync_active),
        .next_visible     (v_visible),
        .next_last        (v_last)
    );

    vga_flags_t flags_next;
    vga_flags_t flags;

    always_comb begin
        flags_next            = FLAGS_RESET;
        flags_next.hsync      = ~h_sync_active;
        flags_next.vsync      = ~v_sync_active;
        flags_next.display_on = h_visible && v_visible;
        flags_next.line_end   = h_last;
        flags_next.frame_end  = h_last && v_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= FLAGS_RESET;
        end else if (ce) begin
            flags <= flags_next;
        end
    end

    assign hsync      = flags.hsync;
    assign vsync      = flags.vsync;
    assign display_on = flags.display_on;
    assign line_end   = flags.line_end;
    assign frame_end  = flags.frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken-raster instance for frame-level behaviour.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

    typedef struct {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic de;
        logic le;
        logic fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_full = 1'b0;
    logic       ce_small = 1'b0;
    logic [9:0] f_x, f_y, s_x, s_y;
    logic       f_hsync, f_vsync, f_de, f_le, f_fe;
    logic       s_hsync, s_vsync, s_de, s_le, s_fe;

    int   checks = 0;
    int   errors = 0;
    int   fx = 0, fy = 0, sx = 0, sy = 0;
    exp_t q_f[$];
    exp_t q_s[$];

    always #5 clk = ~clk;

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .ce(ce_full), .x(f_x), .y(f_y), .hsync(f_hsync),
        .vsync(f_vsync), .display_on(f_de), .line_end(f_le), .frame_end(f_fe)
    );

    vga_timing_gen #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .clk(clk), .rst(rst), .ce(ce_small), .x(s_x), .y(s_y), .hsync(s_hsync),
        .vsync(s_vsync), .display_on(s_de), .line_end(s_le), .frame_end(s_fe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model_out(input int x, input int y, input int hd, input int hf,
                                       input int hs, input int ht, input int vd, input int vf,
                                       input int vs, input int vt);
        exp_t e;
        e.x  = x;
        e.y  = y;
        e.hs = !((x >= hd + hf) && (x < hd + hf + hs));
        e.vs = !((y >= vd + vf) && (y < vd + vf + vs));
        e.de = (x < hd) && (y < vd);
        e.le = (x == ht - 1);
        e.fe = (x == ht - 1) && (y == vt - 1);
        return e;
    endfunction

    task automatic adv(inout int x, inout int y, input int ht, input int vt);
        if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
    endtask

    task automatic cmp_f(input exp_t e);
        chk("f_x", 32'(f_x), e.x);
        chk("f_y", 32'(f_y), e.y);
        chk("f_hsync", 32'(f_hsync), 32'(e.hs));
        chk("f_vsync", 32'(f_vsync), 32'(e.vs));
        chk("f_display_on", 32'(f_de), 32'(e.de));
        chk("f_line_end", 32'(f_le), 32'(e.le));
        chk("f_frame_end", 32'(f_fe), 32'(e.fe));
    endtask

    task automatic cmp_s(input exp_t e);
        chk("s_x", 32'(s_x), e.x);
        chk("s_y", 32'(s_y), e.y);
        chk("s_hsync", 32'(s_hsync), 32'(e.hs));
        chk("s_vsync", 32'(s_vsync), 32'(e.vs));
        chk("s_display_on", 32'(s_de), 32'(e.de));
        chk("s_line_end", 32'(s_le), 32'(e.le));
        chk("s_frame_end", 32'(s_fe), 32'(e.fe));
    endtask

    // Drive one clock of ce values, queue what each instance must show after the edge, then compare.
    task automatic step(input logic cf, input logic cs);
        ce_full  = cf;
        ce_small = cs;
        if (cf) adv(fx, fy, H_TOTAL, V_TOTAL);
        if (cs) adv(sx, sy, S_HT, S_VT);
        q_f.push_back(model_out(fx, fy, H_DISPLAY, H_FRONT, H_SYNC, H_TOTAL,
                                V_DISPLAY, V_FRONT, V_SYNC, V_TOTAL));
        q_s.push_back(model_out(sx, sy, S_HD, S_HF, S_HS, S_HT, S_VD, S_VF, S_VS, S_VT));
        @(posedge clk);
        #1;
        cmp_f(q_f.pop_front());
        cmp_s(q_s.pop_front());
    endtask

    task automatic chk_reset_outputs(input string who);
        chk({who, "_rst_f_x"}, 32'(f_x), 0);
        chk({who, "_rst_f_y"}, 32'(f_y), 0);
        chk({who, "_rst_f_hsync"}, 32'(f_hsync), 1);
        chk({who, "_rst_f_vsync"}, 32'(f_vsync), 1);
        chk({who, "_rst_f_de"}, 32'(f_de), 1);
        chk({who, "_rst_f_le"}, 32'(f_le), 0);
        chk({who, "_rst_f_fe"}, 32'(f_fe), 0);
        chk({who, "_rst_s_x"}, 32'(s_x), 0);
        chk({who, "_rst_s_y"}, 32'(s_y), 0);
        chk({who, "_rst_s_hsync"}, 32'(s_hsync), 1);
        chk({who, "_rst_s_vsync"}, 32'(s_vsync), 1);
        chk({who, "_rst_s_de"}, 32'(s_de), 1);
        chk({who, "_rst_s_le"}, 32'(s_le), 0);
        chk({who, "_rst_s_fe"}, 32'(s_fe), 0);
    endtask

    initial begin
        int hs_low, hs_first, hs_last, le_cnt, le_x;
        int fe_cnt, fe_x, fe_y, vs_low, de_cnt, fe_seen_prev;
        int fe_first_i, fe_last_i, edges, prev_vs, prev_x;
        bit found;

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;

        // One full-size line
        hs_low = 0; hs_first = -1; hs_last = -1; le_cnt = 0; le_x = -1;
        for (int i = 0; i < H_TOTAL; i++) begin
            step(1'b1, 1'b0);
            if (f_hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(f_x);
                hs_last = int'(f_x);
            end
            if (f_le === 1'b1) begin
                le_cnt++;
                le_x = int'(f_x);
            end
        end
        chk("line_wrap_x", 32'(f_x), 0);
        chk("line_wrap_y", 32'(f_y), 1);
        chk("hsync_low_cycles", hs_low, 96);
        chk("hsync_first_x", hs_first, 656);
        chk("hsync_last_x", hs_last, 751);
        chk("line_end_count", le_cnt, 1);
        chk("line_end_x", le_x, 799);

        // One shrunken frame with ce held high
        fe_cnt = 0; fe_x = -1; fe_y = -1; vs_low = 0; de_cnt = 0; fe_seen_prev = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            step(1'b0, 1'b1);
            if (fe_seen_prev != 0) begin
                chk("after_frame_end_x", 32'(s_x), 0);
                chk("after_frame_end_y", 32'(s_y), 0);
            end
            fe_seen_prev = (s_fe === 1'b1) ? 1 : 0;
            if (s_fe === 1'b1) begin
                fe_cnt++;
                fe_x = int'(s_x);
                fe_y = int'(s_y);
            end
            if (s_vsync === 1'b0) vs_low++;
            if (s_de === 1'b1) de_cnt++;
            if (sx == S_HD - 1 && sy == S_VD - 1) chk("de_last_visible", 32'(s_de), 1);
            if (sx == S_HD && sy == S_VD - 1) chk("de_right_of_visible", 32'(s_de), 0);
            if (sx == 0 && sy == S_VD) chk("de_below_visible", 32'(s_de), 0);
        end
        chk("frame_end_count", fe_cnt, 1);
        chk("frame_end_x", fe_x, S_HT - 1);
        chk("frame_end_y", fe_y, S_VT - 1);
        chk("vsync_low_cycles", vs_low, S_VS * S_HT);
        chk("display_on_cycles", de_cnt, S_HD * S_VD);

        // ce toggling: the frame takes twice the clocks and nothing moves on ce=0 cycles
        fe_cnt = 0; fe_first_i = -1; fe_last_i = -1;
        for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
            prev_x = int'(s_x);
            step(1'b0, (i % 2) == 0);
            if ((i % 2) == 1) chk("hold_x", 32'(s_x), prev_x);
            if (s_fe === 1'b1) begin
                fe_cnt++;
                if (fe_first_i < 0) fe_first_i = i;
                fe_last_i = i;
            end
        end
        chk("toggle_frame_end_cycles", fe_cnt, 2);
        chk("toggle_frame_end_consecutive", fe_last_i - fe_first_i, 1);
        chk("toggle_end_x", 32'(s_x), 0);
        chk("toggle_end_y", 32'(s_y), 0);

        // Three frames: one vsync rising edge each, landing on (0, sync end + 1)
        edges = 0;
        prev_vs = 1;
        for (int i = 0; i < 3 * S_HT * S_VT; i++) begin
            step(1'b0, 1'b1);
            if (prev_vs == 0 && s_vsync === 1'b1) begin
                edges++;
                chk("vsync_rise_x", 32'(s_x), 0);
                chk("vsync_rise_y", 32'(s_y), S_VD + S_VF + S_VS);
            end
            prev_vs = (s_vsync === 1'b1) ? 1 : 0;
        end
        chk("vsync_rising_edges", edges, 3);

        // Park inside both sync pulses, then reset asynchronously between edges
        while (!(sx == S_HD + S_HF + 1 && sy == S_VD + S_VF + 1)) step(1'b0, 1'b1);
        chk("pre_reset_hsync", 32'(s_hsync), 0);
        chk("pre_reset_vsync", 32'(s_vsync), 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async");
        #1;
        rst = 1'b0;
        fx = 0; fy = 0; sx = 0; sy = 0;

        found = 1'b0;
        prev_vs = 1;
        for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
            step(1'b0, 1'b1);
            if (prev_vs == 1 && s_vsync === 1'b0) begin
                found = 1'b1;
                chk("vsync_fall_y", 32'(s_y), S_VD + S_VF);
                chk("vsync_fall_x", 32'(s_x), 0);
            end
            prev_vs = (s_vsync === 1'b1) ? 1 : 0;
        end
        chk("vsync_fall_seen", 32'(found), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
